// File: rtl/tristate_bus_arbiter.sv
// Round-robin owner arbiter for a shared tri-state bus.
// States: IDLE (arbitrate), DRIVE (owner drives bus for up to MAX_BURST
// cycles), TURNAROUND (bus released for TA_CYCLES cycles).
// Optional build macro TRISTATE_BUS_KEEPER_EN: when defined, bus_q only
// samples the bus while this block drives it and holds the last driven word
// otherwise; when undefined, bus_q samples the bus on every edge.
module tristate_bus_arbiter #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned CHANNELS  = 4,
  parameter int unsigned MAX_BURST = 4,
  parameter int unsigned TA_CYCLES = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [CHANNELS-1:0]           req,
  input  logic [CHANNELS*WIDTH-1:0]     din,
  inout  wire  [WIDTH-1:0]              bus,
  output logic [CHANNELS-1:0]           grant,
  output logic [$clog2(CHANNELS)-1:0]   owner,
  output logic                          busy,
  output logic [WIDTH-1:0]              bus_q
);

  localparam int unsigned OW = $clog2(CHANNELS);
  localparam int unsigned BW = $clog2(MAX_BURST + 1);
  localparam int unsigned TW = $clog2(TA_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_TURN  = 2'd2
  } state_t;

  state_t               state_q,  state_d;
  logic [CHANNELS-1:0]  grant_q,  grant_d;
  logic [OW-1:0]        owner_q,  owner_d;
  logic [BW-1:0]        burst_q,  burst_d;
  logic [TW-1:0]        ta_q,     ta_d;
  logic                 busy_q,   busy_d;
  logic [WIDTH-1:0]     sample_q, sample_d;

  logic                 arb_found_c;
  logic [OW-1:0]        arb_idx_c;
  logic [OW-1:0]        cand_idx_c;
  logic                 drive_done_c;
  logic                 ta_done_c;
  logic [WIDTH-1:0]     drv_data_c;

  // Round-robin search starting one past the current owner.
  always_comb begin
    arb_found_c = 1'b0;
    arb_idx_c   = '0;
    cand_idx_c  = '0;
    for (int unsigned i = 1; i <= CHANNELS; i++) begin
      cand_idx_c = OW'((32'(owner_q) + i) % CHANNELS);
      if (!arb_found_c && req[cand_idx_c]) begin
        arb_found_c = 1'b1;
        arb_idx_c   = cand_idx_c;
      end
    end
  end

  // Burst and turnaround termination conditions.
  always_comb begin
    drive_done_c = !req[owner_q] || (burst_q == BW'(MAX_BURST));
    ta_done_c    = (ta_q == TW'(TA_CYCLES));
  end

  // Select the granted channel's live data; grant is one-hot so OR-ing is safe.
  always_comb begin
    drv_data_c = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (grant_q[i]) begin
        drv_data_c = drv_data_c | din[i*WIDTH +: WIDTH];
      end
    end
  end

  // Bus is driven only while some channel holds the grant.
  assign bus = (|grant_q) ? drv_data_c : {WIDTH{1'bz}};

  // State register and datapath flops; reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      owner_q  <= OW'(CHANNELS - 1);
      burst_q  <= '0;
      ta_q     <= '0;
      busy_q   <= 1'b0;
      sample_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      owner_q  <= owner_d;
      burst_q  <= burst_d;
      ta_q     <= ta_d;
      busy_q   <= busy_d;
      sample_q <= sample_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_found_c) begin
          state_d = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        if (drive_done_c) begin
          state_d = ST_TURN;
        end
      end
      ST_TURN: begin
        if (ta_done_c) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Grant, owner, counters and busy for the next cycle.
  always_comb begin
    grant_d = grant_q;
    owner_d = owner_q;
    burst_d = burst_q;
    ta_d    = ta_q;
    case (state_q)
      ST_IDLE: begin
        grant_d = '0;
        if (arb_found_c) begin
          grant_d = CHANNELS'(1) << arb_idx_c;
          owner_d = arb_idx_c;
          burst_d = BW'(1);
        end
      end
      ST_DRIVE: begin
        if (drive_done_c) begin
          grant_d = '0;
          ta_d    = TW'(1);
        end else begin
          burst_d = burst_q + BW'(1);
        end
      end
      ST_TURN: begin
        grant_d = '0;
        if (ta_done_c) begin
          ta_d = '0;
        end else begin
          ta_d = ta_q + TW'(1);
        end
      end
      default: begin
        grant_d = '0;
      end
    endcase
    busy_d = (state_d == ST_DRIVE) || (state_d == ST_TURN);
  end

  // Bus sample register, optionally holding the last driven word.
  always_comb begin
`ifdef TRISTATE_BUS_KEEPER_EN
    sample_d = (state_q == ST_DRIVE) ? bus : sample_q;
`else
    sample_d = bus;
`endif
  end

  assign grant = grant_q;
  assign owner = owner_q;
  assign busy  = busy_q;
  assign bus_q = sample_q;

endmodule
